// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: hs/vs/de, active coordinates, line/frame pulses
// and a frame-latched read window (win_de) for the frame-buffer read path.
module video_timing_gen #(
  parameter int CNT_W    = 12,
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] win_x,
  input  logic [CNT_W-1:0] win_y,
  input  logic [CNT_W-1:0] win_w,
  input  logic [CNT_W-1:0] win_h,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [CNT_W-1:0] active_x,
  output logic [CNT_W-1:0] active_y,
  output logic             win_de,
  output logic             frame_start,
  output logic             line_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [CNT_W-1:0] WIN_W_RST  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] WIN_H_RST  = CNT_W'(V_ACTIVE);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] wx_q, wx_d, wy_q, wy_d, ww_q, ww_d, wh_q, wh_d;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d, win_de_q, win_de_d;
  logic             frame_start_q, frame_start_d, line_start_q, line_start_d;
  logic [CNT_W-1:0] active_x_q, active_x_d, active_y_q, active_y_d;

  logic             h_last, v_last, h_act, v_act, in_win;
  logic [CNT_W-1:0] ax, ay;
  logic [CNT_W:0]   x_end, y_end;

  always_comb begin
    h_last = (h_cnt_q == H_LAST);
    v_last = (v_cnt_q == V_LAST);
    h_act  = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END);
    v_act  = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
    ax     = h_cnt_q - H_ACT_BEG;
    ay     = v_cnt_q - V_ACT_BEG;
    // Window ends carry one extra bit so a wide window never wraps back into range.
    x_end  = {1'b0, wx_q} + {1'b0, ww_q};
    y_end  = {1'b0, wy_q} + {1'b0, wh_q};
    in_win = (ax >= wx_q) && ({1'b0, ax} < x_end) &&
             (ay >= wy_q) && ({1'b0, ay} < y_end);

    h_cnt_d       = '0;
    v_cnt_d       = '0;
    hs_d          = ~HS_POL;
    vs_d          = ~VS_POL;
    de_d          = 1'b0;
    win_de_d      = 1'b0;
    frame_start_d = 1'b0;
    line_start_d  = 1'b0;
    active_x_d    = '0;
    active_y_d    = '0;
    wx_d          = wx_q;
    wy_d          = wy_q;
    ww_d          = ww_q;
    wh_d          = wh_q;

    if (en) begin
      h_cnt_d       = h_last ? '0 : h_cnt_q + 1'b1;
      v_cnt_d       = h_last ? (v_last ? '0 : v_cnt_q + 1'b1) : v_cnt_q;
      hs_d          = (h_cnt_q < H_SYNC_END) ? HS_POL : ~HS_POL;
      vs_d          = (v_cnt_q < V_SYNC_END) ? VS_POL : ~VS_POL;
      de_d          = h_act && v_act;
      win_de_d      = h_act && v_act && in_win;
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
      line_start_d  = (h_cnt_q == '0);
      active_x_d    = h_act ? ax : '0;
      active_y_d    = v_act ? ay : '0;
    end

    // Shadow the window only at the frame boundary (or while idle) to avoid tearing.
    if (!en || (h_last && v_last)) begin
      wx_d = win_x;
      wy_d = win_y;
      ww_d = win_w;
      wh_d = win_h;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      de_q          <= 1'b0;
      win_de_q      <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      active_x_q    <= '0;
      active_y_q    <= '0;
      wx_q          <= '0;
      wy_q          <= '0;
      ww_q          <= WIN_W_RST;
      wh_q          <= WIN_H_RST;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      win_de_q      <= win_de_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      active_x_q    <= active_x_d;
      active_y_q    <= active_y_d;
      wx_q          <= wx_d;
      wy_q          <= wy_d;
      ww_q          <= ww_d;
      wh_q          <= wh_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign win_de      = win_de_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign active_x    = active_x_q;
  assign active_y    = active_y_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed-mode HDMI/VGA timing block.
- Produces hs/vs/de, active pixel coordinates, frame/line start pulses, and a runtime-programmable read window (win_de) for the DDR3 frame-buffer read path.
- Window geometry is latched at frame boundaries, so the window can be changed on the fly without tearing.
- Sits between the pixel-clock PLL and the frame-buffer read FIFO / HDMI encoder.

Parameters:
CNT_W, 12, width of h/v counters, coordinates and window inputs
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, horizontal sync width (pixels)
H_BP, 220, horizontal back porch (pixels)
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vertical sync width (lines)
V_BP, 20, vertical back porch (lines)
HS_POL, 1, asserted level of hs
VS_POL, 1, asserted level of vs

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
en  in  1  timing enable; low holds the raster at origin
win_x  in  CNT_W  window left edge (active-pixel coordinate)
win_y  in  CNT_W  window top edge
win_w  in  CNT_W  window width in pixels
win_h  in  CNT_W  window height in lines
hs  out  1  horizontal sync
vs  out  1  vertical sync
de  out  1  active video
active_x  out  CNT_W  active pixel x
active_y  out  CNT_W  active pixel y
win_de  out  1  pixel inside latched window (read request)
frame_start  out  1  one-cycle pulse at raster origin
line_start  out  1  one-cycle pulse at start of every line

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values:
  - hs = ~HS_POL, vs = ~VS_POL.
  - de, win_de, frame_start, line_start = 0.
  - active_x, active_y = 0.
  - h_cnt, v_cnt = 0.
  - Latched window = (0, 0, H_ACTIVE, V_ACTIVE).
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Line order is sync, back porch, active, front porch; frame order is the same.
- Counting:
  - h_cnt counts 0..H_TOTAL-1 and wraps.
  - v_cnt increments when h_cnt == H_TOTAL-1 and wraps from V_TOTAL-1 to 0.
- All outputs are registered functions of the current (h_cnt, v_cnt), giving a fixed 1-cycle latency:
  - hs = HS_POL iff h_cnt < H_SYNC.
  - vs = VS_POL iff v_cnt < V_SYNC; vs therefore changes only on cycles where h_cnt == 0.
  - h_act iff H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE; v_act defined likewise in v.
  - de = h_act & v_act.
  - active_x = h_cnt-(H_SYNC+H_BP) when h_act, else 0; active_y likewise.
  - frame_start = (h_cnt == 0 && v_cnt == 0); line_start = (h_cnt == 0).
- Window:
  - win_x/y/w/h are sampled into shadow registers when h_cnt == H_TOTAL-1 && v_cnt == V_TOTAL-1, and also while en is low.
  - win_de = de & (ax >= wx) & (ax < wx+ww) & (ay >= wy) & (ay < wy+wh), using shadow values, ax/ay = unregistered coordinates, and sums computed at CNT_W+1 bits (no wrap).
  - Width or height of 0 means win_de is never asserted.
  - Windows exceeding the active area are clipped implicitly by de.
- en:
  - While en = 0: counters are held at 0 and outputs are held at their reset values.
  - On the first edge with en = 1: outputs reflect (0, 0), so frame_start = 1, and counting proceeds.
  - Deassertion mid-frame takes effect at the next edge; there is no wait for a frame boundary.
- Asynchronous rst mid-line forces reset values immediately.
- After rst releases, the raster restarts at the origin on the first edge, exactly as on en rising.

Test Plan (H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 -> H_TOTAL=14; V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 -> V_TOTAL=7; frame = 98 cycles):
1. Release rst with en=1 -> frame_start high after edge 1, then every 98 cycles; line_start high every 14 cycles; hs=1 for 2 of every 14 cycles; vs=1 for the first 14 cycles of each frame.
2. Same run -> first de after edge 33 with active_x=0, active_y=0; de high for 8-cycle bursts, 32 cycles per frame; last de has active_x=7, active_y=3.
3. Window (2, 1, 3, 2) programmed before frame start -> win_de only at active_x 2..4 and active_y 1..2, 6 cycles per frame; the same window written mid-frame takes effect only from the next frame_start.
4. Window (6, 0, 10, 4), and window with win_w=0 -> first gives win_de at x=6,7 on all 4 lines (8 cycles, no wrap artefacts); second gives win_de never high.
5. Drop en mid-active-line, hold 5 cycles, raise -> outputs go inactive one edge after the drop; after en rises, frame_start after the first edge and de resumes 33 edges later.
6. Assert rst asynchronously between edges during de -> hs/vs/de drop immediately; after release, sequence matches scenario 1.
